sift_desc_match: RTL and testbench
==================================

// Module: sift_desc_match
// PURPOSE
//  Brute-force L1 matcher between the image-1 descriptors (DESC1_RAM) and the image-2 descriptors (DESC2_RAM).
//  Sits downstream of sift_desc; start is driven by complete4 of sift_desc.
//  For each image-1 keypoint it finds the nearest and second-nearest image-2 descriptor.
//  It streams accepted matches over a valid/ready port to the readout/EPP side.
// PARAMETERS
//  DESC_W    1024  descriptor width in bits (ELEM_W-bit unsigned elements)
//  ELEM_W    8     element width
//  CHUNK     16    elements summed per ACC cycle; NCH = DESC_W/(ELEM_W*CHUNK) = 8
//  KP1_AW    10    DESC1 address width
//  KP2_AW    8     DESC2 address width
//  DIST_W    16    distance width (max 128*255 = 32640, never saturates)
//  RATIO_NUM 4     ratio test numerator (accept if best*RATIO_DEN < second*RATIO_NUM)
//  RATIO_DEN 5     ratio test denominator
// PORTS
//  clk         in   1       system clock (clk_100 domain, same as DESC RAMs)
//  rst         in   1       asynchronous, active-low reset
//  start       in   1       level/pulse; sampled in IDLE only
//  n_kp1       in   KP1_AW  number of valid DESC1 entries; latched on start
//  n_kp2       in   KP2_AW  number of valid DESC2 entries; latched on start
//  desc1_addr  out  KP1_AW  DESC1_RAM read address
//  desc1_q     in   DESC_W  DESC1_RAM data; valid 1 cycle after desc1_addr
//  desc2_addr  out  KP2_AW  DESC2_RAM read address
//  desc2_q     in   DESC_W  DESC2_RAM data; valid 1 cycle after desc2_addr
//  m_valid     out  1       match available
//  m_ready     in   1       consumer accepts match
//  m_idx1      out  KP1_AW  image-1 keypoint index
//  m_idx2      out  KP2_AW  best image-2 keypoint index
//  m_dist      out  DIST_W  best L1 distance
//  busy        out  1       high from start acceptance until DONE
//  done        out  1       one-cycle pulse when the whole pass finishes
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, i=j=0, best=second=all-ones. Reset mid-run aborts immediately; no partial match is emitted.
//  FSM states: IDLE, RD1, WT1, RD2, WT2, ACC, DEC, EMIT, FIN.
//   IDLE: on start, latch n_kp1/n_kp2; busy<=1. If either count is 0 -> FIN, else -> RD1.
//   RD1: desc1_addr<=i -> WT1. WT1: latch desc1_q into d1 reg; best=second=all-ones, j=0 -> RD2.
//   RD2: desc2_addr<=j -> WT2. WT2: latch desc2_q into d2 reg, acc=0, c=0 -> ACC.
//   ACC: acc += sum |d1[e]-d2[e]| over the CHUNK elements of chunk c; NCH cycles total.
//    After the last chunk: if dist<best then second<=best, best<=dist, bidx<=j.
//    Else if dist<second then second<=dist. Ties go to second, so the first-seen index wins.
//    If j==n_kp2-1 -> DEC, else j++ -> RD2.
//   DEC: evaluate accept (see CONFIGURATION). Accept -> EMIT. Reject: i++, then RD1, or FIN if i was n_kp1-1.
//   EMIT: m_valid=1 with m_idx1=i, m_idx2=bidx, m_dist=best, all held stable until m_valid&&m_ready.
//    On that handshake: m_valid<=0, then i++ -> RD1, or -> FIN if i was n_kp1-1.
//   FIN: done=1 for exactly one cycle, busy<=0 -> IDLE.
//  Per-pair cost: 2+NCH cycles. Per-i overhead: 2 (RD1/WT1) + 1 (DEC) + EMIT wait.
//  start while busy is ignored. n_kp1/n_kp2 changes after latch have no effect.
//  Ratio product widths: DIST_W+3 bits, unsigned. Equal products reject; best=second=0 rejects.
//  n_kp2==1: second stays all-ones, so the ratio test passes whenever best < 0.8*65535.
// CONFIGURATION
//  SIFT_MATCH_RATIO_EN defined: accept iff best*RATIO_DEN < second*RATIO_NUM.
//  Undefined: second-best tracking and the comparison are not built. DEC always accepts, so every i emits exactly one match.
// TESTING
//  1. n_kp1=1, n_kp2=3, desc2[1]==desc1[0], desc2[0], desc2[2] all-elements +10
//     -> one match (0,1,0); done pulses once; pair cost 10 cycles.
//  2. Ratio reject: best=100, second=120 -> no match with _EN; match (i,bidx,100) without _EN.
//  3. Tie: desc2[0]==desc2[1]==desc1[0] -> idx2=0 chosen; with _EN rejected (0<0 false).
//  4. n_kp2=0 (or n_kp1=0), start -> FIN next cycle, done pulse, m_valid never rises.
//  5. Backpressure: hold m_ready=0 for 50 cycles -> m_valid/m_idx*/m_dist stable;
//     desc addresses frozen; release -> next i proceeds.
//  6. Assert rst low mid-ACC for i=5 -> all outputs 0 next edge, FSM IDLE.
//     A new start reruns from i=0 with correct results; start pulsed while busy is ignored.

Source files
------------

// File: rtl/sift_desc_match.sv
// sift_desc_match: brute-force L1 nearest/second-nearest matcher between DESC1 and DESC2 descriptors.
// Optional Lowe ratio test is built only when SIFT_MATCH_RATIO_EN is defined.
module sift_desc_match #(
  parameter int DESC_W    = 1024,
  parameter int ELEM_W    = 8,
  parameter int CHUNK     = 16,
  parameter int KP1_AW    = 10,
  parameter int KP2_AW    = 8,
  parameter int DIST_W    = 16,
  parameter int RATIO_NUM = 4,
  parameter int RATIO_DEN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KP1_AW-1:0] n_kp1,
  input  logic [KP2_AW-1:0] n_kp2,
  output logic [KP1_AW-1:0] desc1_addr,
  input  logic [DESC_W-1:0] desc1_q,
  output logic [KP2_AW-1:0] desc2_addr,
  input  logic [DESC_W-1:0] desc2_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [KP1_AW-1:0] m_idx1,
  output logic [KP2_AW-1:0] m_idx2,
  output logic [DIST_W-1:0] m_dist,
  output logic              busy,
  output logic              done
);

  localparam int CH_W = ELEM_W * CHUNK;
  localparam int NCH  = DESC_W / CH_W;
  localparam int C_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [C_W-1:0]    C_LAST = C_W'(NCH - 1);
  localparam logic [DIST_W-1:0] D_ONES = {DIST_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_RD1, S_WT1, S_RD2, S_WT2, S_ACC, S_DEC, S_EMIT, S_FIN
  } state_t;

  function automatic logic [DIST_W-1:0] chunk_l1(input logic [CH_W-1:0] a,
                                                  input logic [CH_W-1:0] b);
    logic [DIST_W-1:0] sum;
    logic [ELEM_W-1:0] ea;
    logic [ELEM_W-1:0] eb;
    sum = {DIST_W{1'b0}};
    for (int e = 0; e < CHUNK; e++) begin
      ea = a[e*ELEM_W +: ELEM_W];
      eb = b[e*ELEM_W +: ELEM_W];
      if (ea > eb) begin
        sum = sum + DIST_W'(ea - eb);
      end else begin
        sum = sum + DIST_W'(eb - ea);
      end
    end
    return sum;
  endfunction

  state_t              state_q, state_d;
  logic [KP1_AW-1:0]   n_kp1_q, n_kp1_d;
  logic [KP2_AW-1:0]   n_kp2_q, n_kp2_d;
  logic [KP1_AW-1:0]   i_q, i_d;
  logic [KP2_AW-1:0]   j_q, j_d;
  logic [C_W-1:0]      c_q, c_d;
  logic [DESC_W-1:0]   d1_q, d1_d;
  logic [DESC_W-1:0]   d2_q, d2_d;
  logic [DIST_W-1:0]   acc_q, acc_d;
  logic [DIST_W-1:0]   best_q, best_d;
  logic [KP2_AW-1:0]   bidx_q, bidx_d;
  logic [KP1_AW-1:0]   desc1_addr_q, desc1_addr_d;
  logic [KP2_AW-1:0]   desc2_addr_q, desc2_addr_d;
  logic                m_valid_q, m_valid_d;
  logic [KP1_AW-1:0]   m_idx1_q, m_idx1_d;
  logic [KP2_AW-1:0]   m_idx2_q, m_idx2_d;
  logic [DIST_W-1:0]   m_dist_q, m_dist_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DIST_W-1:0]   chunk_sum_s;
  logic [DIST_W-1:0]   dist_s;
  logic                last_i_s;
  logic                last_j_s;
  logic                accept_s;

`ifdef SIFT_MATCH_RATIO_EN
  localparam int PROD_W = DIST_W + 3;
  localparam logic [PROD_W-1:0] R_NUM = PROD_W'(RATIO_NUM);
  localparam logic [PROD_W-1:0] R_DEN = PROD_W'(RATIO_DEN);

  logic [DIST_W-1:0] second_q, second_d;
  logic [PROD_W-1:0] best_prod_s;
  logic [PROD_W-1:0] second_prod_s;

  // Ratio test: equal products reject, so best==second (including both zero) never passes.
  always_comb begin
    best_prod_s   = PROD_W'(best_q) * R_DEN;
    second_prod_s = PROD_W'(second_q) * R_NUM;
    accept_s      = (best_prod_s < second_prod_s);
  end
`else
  assign accept_s = 1'b1;
`endif

  // Per-cycle datapath terms: current chunk distance and end-of-loop flags.
  always_comb begin
    chunk_sum_s = chunk_l1(d1_q[c_q*CH_W +: CH_W], d2_q[c_q*CH_W +: CH_W]);
    dist_s      = acc_q + chunk_sum_s;
    last_i_s    = (i_q == (n_kp1_q - 1'b1));
    last_j_s    = (j_q == (n_kp2_q - 1'b1));
  end

  // Next-state and datapath update for the matcher FSM.
  always_comb begin
    state_d  = state_q;
    n_kp1_d  = n_kp1_q;
    n_kp2_d  = n_kp2_q;
    i_d      = i_q;
    j_d      = j_q;
    c_d      = c_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    acc_d    = acc_q;
    best_d   = best_q;
    bidx_d   = bidx_q;
    m_idx1_d = m_idx1_q;
    m_idx2_d = m_idx2_q;
    m_dist_d = m_dist_q;
`ifdef SIFT_MATCH_RATIO_EN
    second_d = second_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_kp1_d = n_kp1;
          n_kp2_d = n_kp2;
          i_d     = {KP1_AW{1'b0}};
          j_d     = {KP2_AW{1'b0}};
          if ((n_kp1 == {KP1_AW{1'b0}}) || (n_kp2 == {KP2_AW{1'b0}})) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD1: state_d = S_WT1;
      S_WT1: begin
        d1_d    = desc1_q;
        best_d  = D_ONES;
`ifdef SIFT_MATCH_RATIO_EN
        second_d = D_ONES;
`endif
        j_d     = {KP2_AW{1'b0}};
        state_d = S_RD2;
      end
      S_RD2: state_d = S_WT2;
      S_WT2: begin
        d2_d    = desc2_q;
        acc_d   = {DIST_W{1'b0}};
        c_d     = {C_W{1'b0}};
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = dist_s;
        if (c_q == C_LAST) begin
          // Strict compares: a later equal distance never displaces the first-seen best.
          if (dist_s < best_q) begin
`ifdef SIFT_MATCH_RATIO_EN
            second_d = best_q;
`endif
            best_d = dist_s;
            bidx_d = j_q;
          end else begin
`ifdef SIFT_MATCH_RATIO_EN
            if (dist_s < second_q) begin
              second_d = dist_s;
            end else begin
              second_d = second_q;
            end
`else
            best_d = best_q;
`endif
          end
          if (last_j_s) begin
            state_d = S_DEC;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = S_RD2;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      S_DEC: begin
        if (accept_s) begin
          m_idx1_d = i_q;
          m_idx2_d = bidx_q;
          m_dist_d = best_q;
          state_d  = S_EMIT;
        end else if (last_i_s) begin
          state_d = S_FIN;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_RD1;
        end
      end
      S_EMIT: begin
        if (m_valid_q && m_ready) begin
          if (last_i_s) begin
            state_d = S_FIN;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = S_RD1;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // RAM addresses follow the next index so the read is already issued in RD1/RD2.
    desc1_addr_d = i_d;
    desc2_addr_d = j_d;
    m_valid_d    = (state_d == S_EMIT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
  end

  // State, datapath and registered outputs; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      n_kp1_q      <= {KP1_AW{1'b0}};
      n_kp2_q      <= {KP2_AW{1'b0}};
      i_q          <= {KP1_AW{1'b0}};
      j_q          <= {KP2_AW{1'b0}};
      c_q          <= {C_W{1'b0}};
      d1_q         <= {DESC_W{1'b0}};
      d2_q         <= {DESC_W{1'b0}};
      acc_q        <= {DIST_W{1'b0}};
      best_q       <= D_ONES;
      bidx_q       <= {KP2_AW{1'b0}};
`ifdef SIFT_MATCH_RATIO_EN
      second_q     <= D_ONES;
`endif
      desc1_addr_q <= {KP1_AW{1'b0}};
      desc2_addr_q <= {KP2_AW{1'b0}};
      m_valid_q    <= 1'b0;
      m_idx1_q     <= {KP1_AW{1'b0}};
      m_idx2_q     <= {KP2_AW{1'b0}};
      m_dist_q     <= {DIST_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_kp1_q      <= n_kp1_d;
      n_kp2_q      <= n_kp2_d;
      i_q          <= i_d;
      j_q          <= j_d;
      c_q          <= c_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      acc_q        <= acc_d;
      best_q       <= best_d;
      bidx_q       <= bidx_d;
`ifdef SIFT_MATCH_RATIO_EN
      second_q     <= second_d;
`endif
      desc1_addr_q <= desc1_addr_d;
      desc2_addr_q <= desc2_addr_d;
      m_valid_q    <= m_valid_d;
      m_idx1_q     <= m_idx1_d;
      m_idx2_q     <= m_idx2_d;
      m_dist_q     <= m_dist_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign desc1_addr = desc1_addr_q;
  assign desc2_addr = desc2_addr_q;
  assign m_valid    = m_valid_q;
  assign m_idx1     = m_idx1_q;
  assign m_idx2     = m_idx2_q;
  assign m_dist     = m_dist_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sift_desc_match.sv
// Self-checking bench for sift_desc_match: directed and randomized passes checked against a
// behavioural nearest/second-nearest model; honours SIFT_MATCH_RATIO_EN when defined.
module tb_sift_desc_match;
  localparam int DESC_W = 1024;
  localparam int ELEM_W = 8;
  localparam int NE     = DESC_W / ELEM_W;
  localparam int KP1_AW = 10;
  localparam int KP2_AW = 8;
  localparam int DIST_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KP1_AW-1:0] n_kp1;
  logic [KP2_AW-1:0] n_kp2;
  logic [KP1_AW-1:0] desc1_addr;
  logic [DESC_W-1:0] desc1_q;
  logic [KP2_AW-1:0] desc2_addr;
  logic [DESC_W-1:0] desc2_q;
  logic              m_valid;
  logic              m_ready;
  logic [KP1_AW-1:0] m_idx1;
  logic [KP2_AW-1:0] m_idx2;
  logic [DIST_W-1:0] m_dist;
  logic              busy;
  logic              done;

  logic [DESC_W-1:0] mem1 [16];
  logic [DESC_W-1:0] mem2 [16];

  typedef struct {
    int i1;
    int i2;
    int d;
  } match_t;
  match_t exp_q[$];

  int checks;
  int errors;

  always #5 clk = ~clk;

  sift_desc_match dut (
    .clk(clk), .rst(rst), .start(start), .n_kp1(n_kp1), .n_kp2(n_kp2),
    .desc1_addr(desc1_addr), .desc1_q(desc1_q),
    .desc2_addr(desc2_addr), .desc2_q(desc2_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx1(m_idx1), .m_idx2(m_idx2),
    .m_dist(m_dist), .busy(busy), .done(done)
  );

  // Synchronous-read RAM models
  always_ff @(posedge clk) begin
    desc1_q <= mem1[desc1_addr[3:0]];
    desc2_q <= mem2[desc2_addr[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DESC_W-1:0] rand_desc(input int maxv);
    logic [DESC_W-1:0] d;
    for (int e = 0; e < NE; e++) d[e*ELEM_W +: ELEM_W] = ELEM_W'($urandom_range(maxv, 0));
    return d;
  endfunction

  function automatic logic [DESC_W-1:0] add_all(input logic [DESC_W-1:0] d, input int k);
    logic [DESC_W-1:0] r;
    for (int e = 0; e < NE; e++) r[e*ELEM_W +: ELEM_W] = ELEM_W'(int'(d[e*ELEM_W +: ELEM_W]) + k);
    return r;
  endfunction

  function automatic int l1(input logic [DESC_W-1:0] a, input logic [DESC_W-1:0] b);
    int s;
    int x;
    int y;
    s = 0;
    for (int e = 0; e < NE; e++) begin
      x = int'(a[e*ELEM_W +: ELEM_W]);
      y = int'(b[e*ELEM_W +: ELEM_W]);
      s += (x > y) ? (x - y) : (y - x);
    end
    return s;
  endfunction

  // Reference: for each image-1 keypoint, nearest and second-nearest by plain search.
  function automatic void build_expected(input int n1, input int n2);
    int best;
    int second;
    int bidx;
    int d;
    bit accept;
    match_t m;
    exp_q.delete();
    if (n1 == 0 || n2 == 0) return;
    for (int i = 0; i < n1; i++) begin
      best = 65535;
      second = 65535;
      bidx = 0;
      for (int j = 0; j < n2; j++) begin
        d = l1(mem1[i], mem2[j]);
        if (d < best) begin
          second = best;
          best = d;
          bidx = j;
        end else if (d < second) begin
          second = d;
        end
      end
`ifdef SIFT_MATCH_RATIO_EN
      accept = (best * 5 < second * 4);
`else
      accept = 1'b1;
`endif
      if (accept) begin
        m.i1 = i;
        m.i2 = bidx;
        m.d = best;
        exp_q.push_back(m);
      end
    end
  endfunction

  // mode 0: m_ready always 1; 1: random m_ready; 2: stall 50 cycles on first match.
  // abort_i >= 0: pull reset once the pass has been in ACC for index abort_i.
  task automatic run_pass(input int n1, input int n2, input int mode, input int abort_i,
                          output int cycles);
    int cyc;
    int stall;
    int after_abort;
    bit fin;
    bit stalled;
    logic [KP1_AW-1:0] a1;
    logic [KP2_AW-1:0] a2;
    cyc = 0;
    stall = 0;
    after_abort = -1;
    fin = 1'b0;
    stalled = 1'b0;
    a1 = '0;
    a2 = '0;
    @(negedge clk);
    n_kp1 = KP1_AW'(n1);
    n_kp2 = KP2_AW'(n2);
    start = 1'b1;
    m_ready = 1'b1;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        n_kp1 = KP1_AW'($urandom);
        n_kp2 = KP2_AW'($urandom);
      end else if (cyc == 12) begin
        start = 1'b1;
      end else if (cyc == 13) begin
        start = 1'b0;
      end
      if (abort_i >= 0) begin
        if (after_abort < 0 && int'(desc1_addr) == abort_i) after_abort = 4;
        else if (after_abort > 0) after_abort--;
        if (after_abort == 0) begin
          rst = 1'b0;
          fin = 1'b1;
        end
      end
      if (!fin) begin
        if (done) fin = 1'b1;
        if (mode == 2 && m_valid && !stalled) begin
          stalled = 1'b1;
          stall = 50;
          a1 = desc1_addr;
          a2 = desc2_addr;
        end
        if (stall > 0) begin
          check("bp_valid", 32'(m_valid), 32'd1);
          check("bp_addr1", 32'(desc1_addr), 32'(a1));
          check("bp_addr2", 32'(desc2_addr), 32'(a2));
          stall--;
          m_ready = 1'b0;
        end else if (mode == 1) begin
          m_ready = 1'($urandom_range(1, 0));
        end else begin
          m_ready = 1'b1;
        end
        if (m_valid) begin
          if (exp_q.size() == 0) begin
            check("extra_match", 32'(m_valid), 32'd0);
          end else begin
            check("m_idx1", 32'(m_idx1), exp_q[0].i1);
            check("m_idx2", 32'(m_idx2), exp_q[0].i2);
            check("m_dist", 32'(m_dist), exp_q[0].d);
            if (m_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
    check("pass_bounded", 32'(fin), 32'd1);
    cycles = cyc;
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_valid_low"}, 32'(m_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_idx1"}, 32'(m_idx1), 32'd0);
    check({tag, "_idx2"}, 32'(m_idx2), 32'd0);
    check({tag, "_dist"}, 32'(m_dist), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_addr1"}, 32'(desc1_addr), 32'd0);
    check({tag, "_addr2"}, 32'(desc2_addr), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [DESC_W-1:0] v;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    n_kp1 = '0;
    n_kp2 = '0;
    m_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      mem1[k] = rand_desc(255);
      mem2[k] = rand_desc(255);
    end
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Exact copy at index 1, uniformly offset neighbours at 0 and 2.
    mem1[0] = rand_desc(245);
    mem2[1] = mem1[0];
    mem2[0] = add_all(mem1[0], 10);
    mem2[2] = mem2[0];
    build_expected(1, 3);
    run_pass(1, 3, 0, -1, cyc);
    check("t1_latency", 32'(cyc), 32'd35);
    check("t1_pending", 32'(exp_q.size()), 32'd0);
    check_idle_after("t1");

    // Ratio case: best 100, second 120.
    v = {NE{8'd100}};
    mem1[0] = v;
    v[7:0] = 8'd200;
    mem2[0] = v;
    v[7:0] = 8'd220;
    mem2[1] = v;
    build_expected(1, 2);
    run_pass(1, 2, 0, -1, cyc);
    check("t2_pending", 32'(exp_q.size()), 32'd0);
    check_idle_after("t2");

    // Tie between two identical candidates.
    mem1[0] = rand_desc(255);
    mem2[0] = mem1[0];
    mem2[1] = mem1[0];
    build_expected(1, 2);
    run_pass(1, 2, 1, -1, cyc);
    check("t3_pending", 32'(exp_q.size()), 32'd0);
    check_idle_after("t3");

    // Empty sets finish straight away.
    build_expected(3, 0);
    run_pass(3, 0, 0, -1, cyc);
    check("t4a_latency", 32'(cyc), 32'd1);
    check_idle_after("t4a");
    build_expected(0, 4);
    run_pass(0, 4, 0, -1, cyc);
    check("t4b_latency", 32'(cyc), 32'd1);
    check_idle_after("t4b");

    // Random descriptors with a guaranteed match for i=0, stalled by backpressure.
    for (int k = 0; k < 16; k++) begin
      mem1[k] = rand_desc(255);
      mem2[k] = rand_desc(255);
    end
    mem2[3] = mem1[0];
    build_expected(6, 5);
    run_pass(6, 5, 2, -1, cyc);
    check("t5_pending", 32'(exp_q.size()), 32'd0);
    check_idle_after("t5");

    mem2[1] = add_all(mem1[2], 0);
    build_expected(4, 3);
    run_pass(4, 3, 1, -1, cyc);
    check("t5b_pending", 32'(exp_q.size()), 32'd0);
    check_idle_after("t5b");

    // Reset during ACC of i=5, then a clean rerun.
    for (int k = 0; k < 16; k++) begin
      mem1[k] = rand_desc(255);
      mem2[k] = rand_desc(255);
    end
    mem2[2] = mem1[3];
    mem2[0] = add_all(mem1[6], 0);
    build_expected(8, 4);
    run_pass(8, 4, 1, 5, cyc);
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b1;
    @(negedge clk);
    build_expected(8, 4);
    run_pass(8, 4, 1, -1, cyc);
    check("t6_pending", 32'(exp_q.size()), 32'd0);
    check_idle_after("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
